// File: rtl/cv32e40p_obi_tracker.sv
// Per-channel OBI transaction tracker: counts outstanding requests, returns the
// {addr, we} of each completing transaction in order, and flags protocol errors.
module cv32e40p_obi_tracker #(
    parameter int NUM_CH = 2,
    parameter int AW     = 32,
    parameter int DEPTH  = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_CH-1:0]          req_i,
    input  logic [NUM_CH-1:0]          gnt_i,
    input  logic [NUM_CH-1:0]          rvalid_i,
    input  logic [NUM_CH-1:0]          we_i,
    input  logic [NUM_CH-1:0][AW-1:0]  addr_i,
    input  logic                       err_clr_i,
    output logic [NUM_CH-1:0][CW-1:0]  outstanding_o,
    output logic [NUM_CH-1:0]          rsp_valid_o,
    output logic [NUM_CH-1:0][AW-1:0]  rsp_addr_o,
    output logic [NUM_CH-1:0]          rsp_we_o,
    output logic [NUM_CH-1:0][3:0]     err_o,
    output logic                       idle_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE,
        WAIT_GNT
    } state_e;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    logic [NUM_CH-1:0] ch_quiet;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_e          state_q;
        logic [AW-1:0]   cap_addr_q;
        logic            cap_we_q;
        logic [CW-1:0]   count_q;
        logic [PW-1:0]   wr_ptr_q;
        logic [PW-1:0]   rd_ptr_q;
        logic [3:0]      err_q;
        logic [AW-1:0]   mem_addr [DEPTH];
        logic            mem_we   [DEPTH];

        logic            accept;
        logic            empty;
        logic            full;
        logic            pop;
        logic            push;
        logic            waiting;
        logic [3:0]      err_set;

        assign accept  = req_i[c] & gnt_i[c];
        assign empty   = (count_q == '0);
        assign full    = (count_q == CW'(DEPTH));
        assign pop     = rvalid_i[c] & ~empty;
        // A pop in the same cycle frees the slot, so a full FIFO may still accept.
        assign push    = accept & (~full | pop);
        assign waiting = (state_q == WAIT_GNT);

        assign err_set[0] = rvalid_i[c] & empty;
        assign err_set[1] = accept & full & ~pop;
        assign err_set[2] = waiting & ~req_i[c];
        assign err_set[3] = waiting & req_i[c] &
                            ((addr_i[c] != cap_addr_q) || (we_i[c] != cap_we_q));

        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q    <= IDLE;
                cap_addr_q <= '0;
                cap_we_q   <= 1'b0;
                count_q    <= '0;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                err_q      <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (req_i[c] && !gnt_i[c]) begin
                            state_q    <= WAIT_GNT;
                            cap_addr_q <= addr_i[c];
                            cap_we_q   <= we_i[c];
                        end
                    end
                    WAIT_GNT: begin
                        if (!req_i[c] || gnt_i[c]) state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase

                if (push && !pop)      count_q <= count_q + CW'(1);
                else if (pop && !push) count_q <= count_q - CW'(1);

                if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
                if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);

                // Set wins over clear so a coincident event is never lost.
                err_q <= (err_q & {4{~err_clr_i}}) | err_set;
            end
        end

        // NOTE: payload storage has no reset; an entry is only ever read after
        // it has been written, so resetting it would only cost reset fan-out.
        always_ff @(posedge clk_i) begin
            if (push) begin
                mem_addr[wr_ptr_q] <= addr_i[c];
                mem_we[wr_ptr_q]   <= we_i[c];
            end
        end

        assign outstanding_o[c] = count_q;
        assign rsp_valid_o[c]   = pop;
        assign rsp_addr_o[c]    = mem_addr[rd_ptr_q];
        assign rsp_we_o[c]      = mem_we[rd_ptr_q];
        assign err_o[c]         = err_q;
        assign ch_quiet[c]      = (state_q == IDLE) & empty;
    end

    assign idle_o = &ch_quiet;

endmodule

// File: tb/tb_cv32e40p_obi_tracker.sv
// Directed table-driven bench for cv32e40p_obi_tracker (NUM_CH=2, AW=32, DEPTH=2).
module tb_cv32e40p_obi_tracker;

    localparam int NUM_CH = 2;
    localparam int AW     = 32;
    localparam int DEPTH  = 2;
    localparam int CW     = $clog2(DEPTH + 1);

    logic                      clk_i = 1'b0;
    logic                      rst_ni;
    logic [NUM_CH-1:0]         req_i;
    logic [NUM_CH-1:0]         gnt_i;
    logic [NUM_CH-1:0]         rvalid_i;
    logic [NUM_CH-1:0]         we_i;
    logic [NUM_CH-1:0][AW-1:0] addr_i;
    logic                      err_clr_i;
    logic [NUM_CH-1:0][CW-1:0] outstanding_o;
    logic [NUM_CH-1:0]         rsp_valid_o;
    logic [NUM_CH-1:0][AW-1:0] rsp_addr_o;
    logic [NUM_CH-1:0]         rsp_we_o;
    logic [NUM_CH-1:0][3:0]    err_o;
    logic                      idle_o;

    int total = 0;
    int bad   = 0;

    cv32e40p_obi_tracker #(
        .NUM_CH (NUM_CH),
        .AW     (AW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_i         (req_i),
        .gnt_i         (gnt_i),
        .rvalid_i      (rvalid_i),
        .we_i          (we_i),
        .addr_i        (addr_i),
        .err_clr_i     (err_clr_i),
        .outstanding_o (outstanding_o),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_addr_o    (rsp_addr_o),
        .rsp_we_o      (rsp_we_o),
        .err_o         (err_o),
        .idle_o        (idle_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  gnt;
        logic [1:0]  rvalid;
        logic [1:0]  we;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        clr;
        logic [1:0]  e_rv;
        logic [1:0]  e_rwe;
        logic [31:0] e_ra0;
        logic [31:0] e_ra1;
        logic [3:0]  e_out;   // {ch1, ch0}
        logic [7:0]  e_err;   // {ch1, ch0}
        logic        e_idle;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic drive(input logic [1:0] req, input logic [1:0] gnt, input logic [1:0] rvalid,
                         input logic [1:0] we, input logic [31:0] a0, input logic [31:0] a1,
                         input logic clr);
        req_i     = req;
        gnt_i     = gnt;
        rvalid_i  = rvalid;
        we_i      = we;
        addr_i[0] = a0;
        addr_i[1] = a1;
        err_clr_i = clr;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [3:0] e_out,
                               input logic [7:0] e_err, input logic e_idle);
        check({tag, " outstanding"}, 64'(outstanding_o), 64'(e_out));
        check({tag, " err"},         64'(err_o),         64'(e_err));
        check({tag, " idle"},        64'(idle_o),        64'(e_idle));
    endtask

    initial begin
        // Ch1 in-order return (0x100, 0x104) with counts 1,2,1,0.
        vecs[0]  = '{2'b10, 2'b10, 2'b00, 2'b00, 32'h0,  32'h100, 1'b0, 2'b00, 2'b00, 32'h0,  32'h0,   4'b0100, 8'h00, 1'b0};
        vecs[1]  = '{2'b10, 2'b10, 2'b00, 2'b00, 32'h0,  32'h104, 1'b0, 2'b00, 2'b00, 32'h0,  32'h0,   4'b1000, 8'h00, 1'b0};
        vecs[2]  = '{2'b00, 2'b00, 2'b10, 2'b00, 32'h0,  32'h0,   1'b0, 2'b10, 2'b00, 32'h0,  32'h100, 4'b0100, 8'h00, 1'b0};
        vecs[3]  = '{2'b00, 2'b00, 2'b10, 2'b00, 32'h0,  32'h0,   1'b0, 2'b10, 2'b00, 32'h0,  32'h104, 4'b0000, 8'h00, 1'b1};
        // Ch0 overflow at DEPTH, then full-FIFO accept with simultaneous pop and pointer wrap.
        vecs[4]  = '{2'b01, 2'b01, 2'b00, 2'b01, 32'h10, 32'h0,   1'b0, 2'b00, 2'b00, 32'h0,  32'h0,   4'b0001, 8'h00, 1'b0};
        vecs[5]  = '{2'b01, 2'b01, 2'b00, 2'b00, 32'h14, 32'h0,   1'b0, 2'b00, 2'b00, 32'h0,  32'h0,   4'b0010, 8'h00, 1'b0};
        vecs[6]  = '{2'b01, 2'b01, 2'b00, 2'b00, 32'h18, 32'h0,   1'b0, 2'b00, 2'b00, 32'h0,  32'h0,   4'b0010, 8'h02, 1'b0};
        vecs[7]  = '{2'b00, 2'b00, 2'b00, 2'b00, 32'h0,  32'h0,   1'b1, 2'b00, 2'b00, 32'h0,  32'h0,   4'b0010, 8'h00, 1'b0};
        vecs[8]  = '{2'b01, 2'b01, 2'b01, 2'b00, 32'h1C, 32'h0,   1'b0, 2'b01, 2'b01, 32'h10, 32'h0,   4'b0010, 8'h00, 1'b0};
        vecs[9]  = '{2'b00, 2'b00, 2'b01, 2'b00, 32'h0,  32'h0,   1'b0, 2'b01, 2'b00, 32'h14, 32'h0,   4'b0001, 8'h00, 1'b0};
        vecs[10] = '{2'b00, 2'b00, 2'b01, 2'b00, 32'h0,  32'h0,   1'b0, 2'b01, 2'b00, 32'h1C, 32'h0,   4'b0000, 8'h00, 1'b1};
        // Ch1 unexpected rvalid, clear, clear coincident with a new event.
        vecs[11] = '{2'b00, 2'b00, 2'b10, 2'b00, 32'h0,  32'h0,   1'b0, 2'b00, 2'b00, 32'h0,  32'h0,   4'b0000, 8'h10, 1'b1};
        vecs[12] = '{2'b00, 2'b00, 2'b00, 2'b00, 32'h0,  32'h0,   1'b1, 2'b00, 2'b00, 32'h0,  32'h0,   4'b0000, 8'h00, 1'b1};
        vecs[13] = '{2'b00, 2'b00, 2'b10, 2'b00, 32'h0,  32'h0,   1'b1, 2'b00, 2'b00, 32'h0,  32'h0,   4'b0000, 8'h10, 1'b1};
        vecs[14] = '{2'b00, 2'b00, 2'b00, 2'b00, 32'h0,  32'h0,   1'b1, 2'b00, 2'b00, 32'h0,  32'h0,   4'b0000, 8'h00, 1'b1};
        // Same-cycle accept does not legitimise an rvalid on an empty channel.
        vecs[15] = '{2'b10, 2'b10, 2'b10, 2'b00, 32'h0,  32'h300, 1'b0, 2'b00, 2'b00, 32'h0,  32'h0,   4'b0100, 8'h10, 1'b0};
        vecs[16] = '{2'b00, 2'b00, 2'b10, 2'b00, 32'h0,  32'h0,   1'b1, 2'b10, 2'b00, 32'h0,  32'h300, 4'b0000, 8'h00, 1'b1};

        drive(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0);
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check_state("reset", 4'b0000, 8'h00, 1'b1);
        check("reset rsp_valid", 64'(rsp_valid_o), 64'(0));
        rst_ni = 1'b1;
        next_cycle();

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].req, vecs[i].gnt, vecs[i].rvalid, vecs[i].we, vecs[i].a0, vecs[i].a1, vecs[i].clr);
            @(negedge clk_i);
            check($sformatf("v%0d rsp_valid", i), 64'(rsp_valid_o), 64'(vecs[i].e_rv));
            for (int c = 0; c < NUM_CH; c++) begin
                if (vecs[i].e_rv[c]) begin
                    check($sformatf("v%0d rsp_addr%0d", i, c), 64'(rsp_addr_o[c]),
                          64'((c == 0) ? vecs[i].e_ra0 : vecs[i].e_ra1));
                    check($sformatf("v%0d rsp_we%0d", i, c), 64'(rsp_we_o[c]), 64'(vecs[i].e_rwe[c]));
                end
            end
            next_cycle();
            check_state($sformatf("v%0d", i), vecs[i].e_out, vecs[i].e_err, vecs[i].e_idle);
        end

        // Address changes while waiting for grant.
        drive(2'b01, 2'b00, 2'b00, 2'b00, 32'h200, 32'h0, 1'b0);
        next_cycle();
        check_state("wait0", 4'b0000, 8'h00, 1'b0);
        drive(2'b01, 2'b00, 2'b00, 2'b00, 32'h204, 32'h0, 1'b0);
        next_cycle();
        check_state("addr_change", 4'b0000, 8'h08, 1'b0);
        drive(2'b01, 2'b01, 2'b00, 2'b00, 32'h204, 32'h0, 1'b0);
        next_cycle();
        check_state("late_grant", 4'b0001, 8'h08, 1'b0);
        drive(2'b00, 2'b00, 2'b01, 2'b00, 32'h0, 32'h0, 1'b1);
        @(negedge clk_i);
        check("late_grant rsp_addr0", 64'(rsp_addr_o[0]), 64'(32'h204));
        next_cycle();
        check_state("drain_a", 4'b0000, 8'h00, 1'b1);

        // Mismatch only in the granting cycle (we flips).
        drive(2'b01, 2'b00, 2'b00, 2'b00, 32'h400, 32'h0, 1'b0);
        next_cycle();
        drive(2'b01, 2'b01, 2'b00, 2'b01, 32'h400, 32'h0, 1'b0);
        next_cycle();
        check_state("grant_cycle_mismatch", 4'b0001, 8'h08, 1'b0);
        drive(2'b00, 2'b00, 2'b01, 2'b00, 32'h0, 32'h0, 1'b1);
        next_cycle();
        check_state("drain_b", 4'b0000, 8'h00, 1'b1);

        // Request retracted before grant.
        drive(2'b01, 2'b00, 2'b00, 2'b00, 32'h500, 32'h0, 1'b0);
        next_cycle();
        check_state("wait_retract", 4'b0000, 8'h00, 1'b0);
        drive(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0);
        next_cycle();
        check_state("retract", 4'b0000, 8'h04, 1'b1);
        drive(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b1);
        next_cycle();
        check_state("retract_clr", 4'b0000, 8'h00, 1'b1);

        // Reset mid-transaction discards outstanding entries.
        drive(2'b01, 2'b01, 2'b00, 2'b00, 32'h600, 32'h0, 1'b0);
        next_cycle();
        drive(2'b01, 2'b01, 2'b00, 2'b00, 32'h604, 32'h0, 1'b0);
        next_cycle();
        check_state("pre_reset", 4'b0010, 8'h00, 1'b0);
        drive(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0);
        rst_ni = 1'b0;
        #1;
        check_state("async_reset", 4'b0000, 8'h00, 1'b1);
        next_cycle();
        rst_ni = 1'b1;
        drive(2'b00, 2'b00, 2'b01, 2'b00, 32'h0, 32'h0, 1'b0);
        @(negedge clk_i);
        check("post_reset rsp_valid", 64'(rsp_valid_o), 64'(0));
        next_cycle();
        check_state("post_reset rvalid", 4'b0000, 8'h01, 1'b1);
        drive(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0);
        next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cv32e40p_obi_tracker.md
CV32E40P_OBI_TRACKER -- requirements
Module: cv32e40p_obi_tracker

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of independent OBI channels (channel 0 = instr, channel 1 = data when used around the core).
REQ-002 SHALL have parameter AW, default 32, address width in bits.
REQ-003 SHALL have parameter DEPTH, default 2, maximum outstanding transactions per channel (DEPTH >= 1); CW = $clog2(DEPTH+1).
REQ-004 SHALL have port clk_i  input  1  single clock; all state rising-edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_i  input  [NUM_CH-1:0]  OBI request per channel.
REQ-007 SHALL have port gnt_i  input  [NUM_CH-1:0]  OBI grant per channel.
REQ-008 SHALL have port rvalid_i  input  [NUM_CH-1:0]  OBI response valid per channel.
REQ-009 SHALL have port we_i  input  [NUM_CH-1:0]  write enable per channel.
REQ-010 SHALL have port addr_i  input  [NUM_CH-1:0][AW-1:0]  request address per channel.
REQ-011 SHALL have port err_clr_i  input  1  clears all sticky error bits.
REQ-012 SHALL have port outstanding_o  output  [NUM_CH-1:0][CW-1:0]  accepted, unanswered transaction count.
REQ-013 SHALL have port rsp_valid_o  output  [NUM_CH-1:0]  legal response completing this cycle.
REQ-014 SHALL have port rsp_addr_o  output  [NUM_CH-1:0][AW-1:0]  address of the completing transaction.
REQ-015 SHALL have port rsp_we_o  output  [NUM_CH-1:0]  we of the completing transaction.
REQ-016 SHALL have port err_o  output  [NUM_CH-1:0][3:0]  sticky errors: [0] unexpected rvalid, [1] overflow, [2] req retracted, [3] addr/we changed while waiting.
REQ-017 SHALL have port idle_o  output  1  high when all channels are in IDLE with zero outstanding.

Function
REQ-018 Accept on channel c SHALL be req_i[c] & gnt_i[c]; accepted {addr, we} SHALL be pushed to a per-channel DEPTH-entry FIFO.
REQ-019 Per-channel FSM SHALL have states IDLE and WAIT_GNT: IDLE with req & ~gnt -> WAIT_GNT, capturing addr/we; IDLE with req & gnt -> IDLE; WAIT_GNT with req & gnt -> IDLE; WAIT_GNT with req & ~gnt -> stay; WAIT_GNT with ~req -> IDLE and set err[2].
REQ-020 In WAIT_GNT with req high, addr_i or we_i differing from the captured value SHALL set err[3]; the check SHALL also apply in the granting cycle.
REQ-021 rsp_valid_o[c] SHALL be combinational rvalid_i[c] & (outstanding != 0), with rsp_addr_o/rsp_we_o equal to the FIFO head (zero latency); the head SHALL be popped on that cycle.
REQ-022 rvalid_i with outstanding == 0 SHALL set err[0], SHALL NOT pop, and SHALL leave rsp_valid_o low; a same-cycle accept SHALL NOT satisfy it.
REQ-023 Accept with outstanding == DEPTH and no same-cycle legal pop SHALL set err[1] and SHALL NOT push; the count SHALL saturate at DEPTH.
REQ-024 Simultaneous accept and legal pop SHALL push and pop, leaving the count unchanged, including at count == DEPTH.
REQ-025 FIFO pointers SHALL wrap modulo DEPTH; entries SHALL be returned in acceptance order.
REQ-026 err_o bits SHALL be sticky until err_clr_i; if a set event coincides with err_clr_i, the bit SHALL read 1 next cycle.
REQ-027 idle_o SHALL be registered-state-derived only: all FSMs in IDLE and all counts zero.
REQ-028 Channels SHALL be fully independent; no event on one channel SHALL affect another.

Reset
REQ-029 On rst_ni low, asynchronously: FSMs to IDLE, counts and FIFO pointers to 0, err_o to 0, captured addr/we to 0; hence outstanding_o = 0, rsp_valid_o = 0, idle_o = 1.
REQ-030 Reset asserted mid-transaction SHALL discard all outstanding entries; rvalid_i after release with count 0 SHALL set err[0].

Verification
REQ-031 Ch1: req+gnt addr 0x100, next cycle req+gnt addr 0x104, then rvalid two cycles -> outstanding 1,2,1,0; rsp_addr_o 0x100 then 0x104.
REQ-032 DEPTH=2, ch0: two accepts, third req+gnt with no rvalid -> err_o[0][1]=1, outstanding stays 2; repeat with rvalid same cycle -> no error, count 2.
REQ-033 Ch0: req high, gnt low 2 cycles, addr changes 0x200->0x204 -> err_o[0][3]=1; separate run dropping req before gnt -> err_o[0][2]=1, FSM IDLE.
REQ-034 rvalid_i[1] with count 0 -> err_o[1][0]=1, rsp_valid_o[1]=0, err_o[0]=0; pulse err_clr_i -> 0 next cycle; clear coincident with new event -> stays 1.
REQ-035 Two accepts outstanding, rst_ni low for 1 cycle -> outstanding 0, idle_o 1, err_o 0; then rvalid -> err[0] set.
